// File: rtl/mmio_kbd_dsp_dev.sv
// LC-3 keyboard/display MMIO device: KBDR/KBSR/DDR/DSR with key FIFO.
// Optional macro MMIO_IRQ_EN adds a registered interrupt request.
module mmio_kbd_dsp_dev #(
    parameter int KBD_DEPTH = 4,
    parameter int DSP_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_data,
    input  logic        ld_kbsr,
    input  logic        ld_ddr,
    input  logic        ld_dsr,
    input  logic        rd_kbdr,
    output logic [15:0] kbdr,
    output logic [15:0] kbsr,
    output logic [15:0] dsr,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    output logic        key_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        irq
);

    localparam int AW = $clog2(KBD_DEPTH);
    localparam int GW = (DSP_GAP < 1) ? 1 : $clog2(DSP_GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } dsp_st_e;

    logic [7:0]    mem_q [KBD_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   cnt_q;
    logic          kbie_q;
    logic          empty, full, push, pop;

    dsp_st_e       state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          ovr_q, ovr_d;
    logic          dsie_q, dsie_d;
    logic          dsp_rdy;

    logic          unused_bus;
    assign unused_bus = ^{bus_data[15], bus_data[12:8]};

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(KBD_DEPTH));
    assign push  = key_valid & ~full;
    assign pop   = rd_kbdr & ~empty;

    // Keyboard FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KBD_DEPTH; i++) mem_q[i] <= 8'h00;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= key_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    // Keyboard interrupt enable bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       kbie_q <= 1'b0;
        else if (ld_kbsr) kbie_q <= bus_data[14];
    end

    // Display FSM next state, DSR control bits and overrun tracking.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        dsie_d  = dsie_q;
        if (ld_dsr) begin
            dsie_d = bus_data[14];
            if (!bus_data[13]) ovr_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (ld_ddr) begin
                    data_d  = bus_data[7:0];
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (ld_ddr) ovr_d = 1'b1;
                if (dsp_ready) begin
                    valid_d = 1'b0;
                    if (DSP_GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GW'(DSP_GAP);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (ld_ddr) ovr_d = 1'b1;
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display FSM and DSR register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            ovr_q   <= 1'b0;
            dsie_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            dsie_q  <= dsie_d;
        end
    end

    assign dsp_rdy   = (state_q == S_IDLE);
    assign kbdr      = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
    assign kbsr      = {~empty, kbie_q, 14'b0};
    assign dsr       = {dsp_rdy, dsie_q, ovr_q, 13'b0};
    assign key_ready = ~full;
    assign dsp_valid = valid_q;
    assign dsp_data  = data_q;

`ifdef MMIO_IRQ_EN
    logic irq_q;

    // Interrupt request trails the status/enable bits by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (~empty & kbie_q) | (dsp_rdy & dsie_q);
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_kbd_dsp_dev.sv
// Self-checking bench for mmio_kbd_dsp_dev.
// Directed steps then random traffic against a queue-based model.
module tb_mmio_kbd_dsp_dev;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic        clk, rst_n;
    logic [15:0] bus_data;
    logic        ld_kbsr, ld_ddr, ld_dsr, rd_kbdr;
    logic [15:0] kbdr, kbsr, dsr;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_ready, dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready, irq;

    int total = 0;
    int bad   = 0;

    byte unsigned q[$];
    bit   kie, die, m_valid, m_rdy, m_ovr, m_irq;
    logic [7:0] m_data;
    int   m_gap;

    mmio_kbd_dsp_dev #(.KBD_DEPTH(DEPTH), .DSP_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .bus_data(bus_data),
        .ld_kbsr(ld_kbsr), .ld_ddr(ld_ddr), .ld_dsr(ld_dsr),
        .rd_kbdr(rd_kbdr), .kbdr(kbdr), .kbsr(kbsr), .dsr(dsr),
        .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready), .dsp_valid(dsp_valid),
        .dsp_data(dsp_data), .dsp_ready(dsp_ready), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        kie = 0; die = 0; m_valid = 0; m_rdy = 1;
        m_ovr = 0; m_irq = 0; m_data = 8'h00; m_gap = 0;
    endtask

    task automatic model_step();
        bit idle_pre, irqn, pu, po;
        idle_pre = m_rdy;
        irqn = (q.size() > 0 && kie) || (m_rdy && die);
        pu = key_valid && (q.size() < DEPTH);
        po = rd_kbdr && (q.size() > 0);
        if (po) void'(q.pop_front());
        if (pu) q.push_back(key_data);
        if (ld_kbsr) kie = bus_data[14];
        if (ld_dsr) begin
            die = bus_data[14];
            if (!bus_data[13]) m_ovr = 0;
        end
        if (m_valid) begin
            if (dsp_ready) begin
                m_valid = 0;
                m_gap = GAP;
                if (GAP == 0) m_rdy = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_rdy = 1;
        end else if (ld_ddr) begin
            m_data = bus_data[7:0];
            m_valid = 1;
            m_rdy = 0;
        end
        if (ld_ddr && !idle_pre) m_ovr = 1;
`ifdef MMIO_IRQ_EN
        m_irq = irqn;
`else
        m_irq = 0;
`endif
    endtask

    task automatic check_all(input string t);
        chk({t, ".kbdr"}, kbdr,
            (q.size() > 0) ? {8'h00, q[0]} : 16'h0000);
        chk({t, ".kbsr"}, kbsr, {q.size() > 0, kie, 14'b0});
        chk({t, ".key_ready"}, {15'b0, key_ready},
            {15'b0, q.size() < DEPTH});
        chk({t, ".dsr"}, dsr, {m_rdy, die, m_ovr, 13'b0});
        chk({t, ".dsp_valid"}, {15'b0, dsp_valid}, {15'b0, m_valid});
        chk({t, ".dsp_data"}, {8'h00, dsp_data}, {8'h00, m_data});
        chk({t, ".irq"}, {15'b0, irq}, {15'b0, m_irq});
    endtask

    task automatic clr();
        bus_data = 16'h0000; ld_kbsr = 0; ld_ddr = 0; ld_dsr = 0;
        rd_kbdr = 0; key_valid = 0; key_data = 8'h00; dsp_ready = 0;
    endtask

    task automatic tick(input string t);
        model_step();
        @(posedge clk);
        #1;
        clr();
        check_all(t);
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst.kbsr", kbsr, 16'h0000);
        chk("rst.dsr", dsr, 16'h8000);
        chk("rst.kbdr", kbdr, 16'h0000);
        chk("rst.key_ready", {15'b0, key_ready}, 16'h0001);
        chk("rst.dsp_valid", {15'b0, dsp_valid}, 16'h0000);
        chk("rst.irq", {15'b0, irq}, 16'h0000);
        check_all("rst");

        key_valid = 1; key_data = 8'h41; tick("push41");
        key_valid = 1; key_data = 8'h42; tick("push42");
        chk("two.kbsr", kbsr, 16'h8000);
        chk("two.kbdr", kbdr, 16'h0041);
        rd_kbdr = 1; tick("pop1");
        chk("pop1.kbdr", kbdr, 16'h0042);
        rd_kbdr = 1; tick("pop2");
        chk("pop2.kbsr", kbsr, 16'h0000);
        rd_kbdr = 1; tick("pop_empty");
        chk("pop_empty.kbsr", kbsr, 16'h0000);
        chk("pop_empty.kbdr", kbdr, 16'h0000);

        for (int i = 0; i < DEPTH; i++) begin
            key_valid = 1; key_data = 8'h50 + 8'(i); tick("fill");
        end
        chk("full.key_ready", {15'b0, key_ready}, 16'h0000);
        key_valid = 1; key_data = 8'h60; tick("full_push");
        chk("full_push.kbdr", kbdr, 16'h0050);
        rd_kbdr = 1; key_valid = 1; key_data = 8'h60; tick("full_pop");
        chk("full_pop.kbdr", kbdr, 16'h0051);
        chk("full_pop.key_ready", {15'b0, key_ready}, 16'h0001);
        key_valid = 1; key_data = 8'h60; tick("refill");
        chk("refill.key_ready", {15'b0, key_ready}, 16'h0000);
        repeat (DEPTH) begin
            rd_kbdr = 1; tick("drain");
        end
        chk("drain.kbsr", kbsr, 16'h0000);

        ld_ddr = 1; bus_data = 16'h1258; tick("ddr");
        chk("ddr.dsp_data", {8'h00, dsp_data}, 16'h0058);
        chk("ddr.dsp_valid", {15'b0, dsp_valid}, 16'h0001);
        chk("ddr.dsr", dsr, 16'h0000);
        repeat (3) begin
            tick("hold");
            chk("hold.dsp_data", {8'h00, dsp_data}, 16'h0058);
        end
        ld_ddr = 1; bus_data = 16'h0061; tick("ovr");
        chk("ovr.dsp_data", {8'h00, dsp_data}, 16'h0058);
        chk("ovr.dsr", dsr, 16'h2000);
        dsp_ready = 1; tick("accept");
        chk("accept.dsp_valid", {15'b0, dsp_valid}, 16'h0000);
        chk("accept.dsr", dsr, 16'h2000);
        tick("gap1");
        chk("gap1.dsr", dsr, 16'h2000);
        tick("gap2");
        chk("gap2.dsr", dsr, 16'hA000);
        ld_dsr = 1; bus_data = 16'h0000; tick("dsrclr");
        chk("dsrclr.dsr", dsr, 16'h8000);

        ld_ddr = 1; bus_data = 16'h0011; tick("ddr2");
        ld_ddr = 1; ld_dsr = 1; bus_data = 16'h0000; tick("ovr_win");
        chk("ovr_win.dsr", dsr, 16'h2000);
        dsp_ready = 1; tick("accept2");
        repeat (GAP) tick("gap");
        ld_dsr = 1; bus_data = 16'h0000; tick("dsrclr2");

        ld_kbsr = 1; bus_data = 16'h4000; tick("kie");
        chk("kie.kbsr", kbsr, 16'h4000);
        key_valid = 1; key_data = 8'h30; tick("push30");
        chk("push30.kbsr", kbsr, 16'hC000);
        chk("push30.irq", {15'b0, irq}, 16'h0000);
        tick("irq_on");
`ifdef MMIO_IRQ_EN
        chk("irq_on.irq", {15'b0, irq}, 16'h0001);
`else
        chk("irq_on.irq", {15'b0, irq}, 16'h0000);
`endif
        rd_kbdr = 1; tick("irq_pop");
        tick("irq_off");
        chk("irq_off.irq", {15'b0, irq}, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            key_valid = 1'($urandom % 2);
            key_data  = 8'($urandom);
            rd_kbdr   = ($urandom % 3) == 0;
            ld_ddr    = ($urandom % 4) == 0;
            ld_dsr    = ($urandom % 8) == 0;
            ld_kbsr   = ($urandom % 8) == 0;
            bus_data  = 16'($urandom);
            dsp_ready = 1'($urandom % 2);
            tick("rnd");
        end

        key_valid = 1; key_data = 8'h77; tick("pre_rst_key");
        while (!m_rdy) tick("pre_rst_wait");
        ld_ddr = 1; bus_data = 16'h00AA; tick("pre_rst_ddr");
        chk("pre_rst.dsp_valid", {15'b0, dsp_valid}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.dsp_valid", {15'b0, dsp_valid}, 16'h0000);
        chk("midrst.dsp_data", {8'h00, dsp_data}, 16'h0000);
        chk("midrst.kbsr", kbsr, 16'h0000);
        chk("midrst.dsr", dsr, 16'h8000);
        chk("midrst.key_ready", {15'b0, key_ready}, 16'h0001);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
